alu_cmd_issuer: RTL

- Upstream stage feeding the arithmetic/logic unit.
- Accepts one command packet per valid/ready handshake and drives the ALU operand/control ports with the required hold timing.
- Waits the command-dependent ALU latency, then captures RES/COUT/EGL/OF/ERR into a tagged response packet with valid/ready backpressure.
- Sits between the command source (bus bridge or FIFO) and the ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_lat_counter.sv | 32 +++
 rtl/alu_cmd_issuer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings, FSM states and default latencies for the ALU command issuer.
package alu_pkg;

    localparam logic [3:0] CMD_MUL_INC = 4'd9;
    localparam logic [3:0] CMD_MUL_SHL = 4'd10;

    localparam int LAT_STD_DEF = 1;
    localparam int LAT_MUL_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Multiplies only exist in arithmetic mode; the same codes are logical ops otherwise.
    function automatic logic is_mul_cmd(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Down-counter for ALU latency: load a value, decrement while enabled, flag zero.
module alu_lat_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero = (r_cnt == {CNT_W{1'b0}});
    assign o_zero = w_zero;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && !w_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to the ALU, waits its latency and returns a tagged response.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int W       = 8,
    parameter int LAT_STD = LAT_STD_DEF,
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int ID_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [ID_W-1:0] req_id,
    input  logic [W-1:0]    req_opa,
    input  logic [W-1:0]    req_opb,
    input  logic [3:0]      req_cmd,
    input  logic            req_mode,
    input  logic            req_cin,
    input  logic [1:0]      req_inp_valid,
    output logic            alu_ce,
    output logic            alu_mode,
    output logic            alu_cin,
    output logic [1:0]      alu_in_valid,
    output logic [3:0]      alu_cmd,
    output logic [W-1:0]    alu_opa,
    output logic [W-1:0]    alu_opb,
    input  logic [2*W-1:0]  alu_res,
    input  logic            alu_cout,
    input  logic            alu_of,
    input  logic            alu_err,
    input  logic [2:0]      alu_egl,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [ID_W-1:0] rsp_id,
    output logic [2*W-1:0]  rsp_res,
    output logic            rsp_cout,
    output logic            rsp_of,
    output logic            rsp_err,
    output logic [2:0]      rsp_egl,
    output logic            busy,
    output logic [15:0]     cmd_count
);

    localparam int LAT_MAX = (LAT_STD > LAT_MUL) ? LAT_STD : LAT_MUL;
    localparam int CNT_W   = (LAT_MAX > 0) ? $clog2(LAT_MAX + 1) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_accept_bad;
    logic             w_load;
    logic             w_capture;
    logic             w_rsp_done;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_lat;

    logic             r_req_ready;
    logic             r_busy;
    logic             r_alu_ce;
    logic             r_alu_mode;
    logic             r_alu_cin;
    logic [1:0]       r_alu_in_valid;
    logic [3:0]       r_alu_cmd;
    logic [W-1:0]     r_alu_opa;
    logic [W-1:0]     r_alu_opb;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [2*W-1:0]   r_rsp_res;
    logic             r_rsp_cout;
    logic             r_rsp_of;
    logic             r_rsp_err;
    logic [2:0]       r_rsp_egl;
    logic [15:0]      r_cmd_count;

    assign w_lat = is_mul_cmd(req_mode, req_cmd) ? CNT_W'(LAT_MUL) : CNT_W'(LAT_STD);

    alu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_lat),
        .i_dec      (r_state == S_WAIT),
        .o_zero     (w_cnt_zero)
    );

    // Next-state and per-edge strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_accept_bad = 1'b0;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (req_inp_valid == 2'b00) begin
                        // No operands: answer with an error and leave the ALU alone.
                        w_accept_bad = 1'b1;
                        w_state_nxt  = S_RESP;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_cnt_zero) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_alu_ce    <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_alu_ce    <= (w_state_nxt == S_WAIT);
        end
    end

    // ALU drive registers: loaded on a valid accept, held afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_mode     <= 1'b0;
            r_alu_cin      <= 1'b0;
            r_alu_in_valid <= 2'b00;
            r_alu_cmd      <= 4'd0;
            r_alu_opa      <= {W{1'b0}};
            r_alu_opb      <= {W{1'b0}};
        end else if (w_load) begin
            r_alu_mode     <= req_mode;
            r_alu_cin      <= req_cin;
            r_alu_in_valid <= req_inp_valid;
            r_alu_cmd      <= req_cmd;
            r_alu_opa      <= req_opa;
            r_alu_opb      <= req_opb;
        end else if (w_capture) begin
            r_alu_in_valid <= 2'b00;
        end else begin
            r_alu_in_valid <= r_alu_in_valid;
        end
    end

    // Response payload: tag at accept, flags from the ALU or the operand error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_id   <= {ID_W{1'b0}};
            r_rsp_res  <= {(2*W){1'b0}};
            r_rsp_cout <= 1'b0;
            r_rsp_of   <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_egl  <= 3'b000;
        end else if (w_accept_bad) begin
            r_rsp_id   <= req_id;
            r_rsp_res  <= {(2*W){1'b0}};
            r_rsp_cout <= 1'b0;
            r_rsp_of   <= 1'b0;
            r_rsp_err  <= 1'b1;
            r_rsp_egl  <= 3'b000;
        end else if (w_accept) begin
            r_rsp_id   <= req_id;
        end else if (w_capture) begin
            r_rsp_res  <= alu_res;
            r_rsp_cout <= alu_cout;
            r_rsp_of   <= alu_of;
            r_rsp_err  <= alu_err;
            r_rsp_egl  <= alu_egl;
        end else begin
            r_rsp_id   <= r_rsp_id;
        end
    end

    // Response valid; the error path raises it one edge after entering RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
        end else if ((r_state == S_RESP) && !r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    // Completed-response counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd_count <= 16'd0;
        end else if (w_rsp_done) begin
            r_cmd_count <= r_cmd_count + 16'd1;
        end else begin
            r_cmd_count <= r_cmd_count;
        end
    end

    assign req_ready    = r_req_ready;
    assign busy         = r_busy;
    assign alu_ce       = r_alu_ce;
    assign alu_mode     = r_alu_mode;
    assign alu_cin      = r_alu_cin;
    assign alu_in_valid = r_alu_in_valid;
    assign alu_cmd      = r_alu_cmd;
    assign alu_opa      = r_alu_opa;
    assign alu_opb      = r_alu_opb;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_res      = r_rsp_res;
    assign rsp_cout     = r_rsp_cout;
    assign rsp_of       = r_rsp_of;
    assign rsp_err      = r_rsp_err;
    assign rsp_egl      = r_rsp_egl;
    assign cmd_count    = r_cmd_count;

endmodule
